// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep generator.
//   tt_state_e    : sweep FSM state encoding
//   TT_SETTLE_DEF : default number of hold cycles per input code
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } tt_state_e;

  localparam int TT_SETTLE_DEF = 2;

endpackage

// File: rtl/tt_settle_ctr.sv
// Hold-time counter for the sweep generator.
// Counts 0..SETTLE-1 while en is high and raises tick on the last hold
// cycle, returning to 0 on the same edge.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   clr   : force the count back to 0 (start of a new sweep)
//   en    : count enable (sweep running)
//   tick  : high during the last hold cycle of the current code
module tt_settle_ctr
  import tt_pkg::*;
#(
  parameter int SETTLE = TT_SETTLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] settle_cnt;

  assign tick = en && (settle_cnt == CW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)      settle_cnt <= '0;
    else if (clr)    settle_cnt <= '0;
    else if (tick)   settle_cnt <= '0;
    else if (en)     settle_cnt <= settle_cnt + CW'(1);
  end

endmodule

// File: rtl/tt_sweep_gen.sv
// Exhaustive truth-table sequencer for a small combinational cell.
// On start, drives every input code 0..2**N_IN-1 in order, holds each code
// for SETTLE cycles and samples y_in on the last hold cycle into table_out.
// Optional build macro TT_CHECK_EN adds a golden-table comparator.
//   clk       : rising-edge clock
//   rst_n     : synchronous reset, active-low
//   start     : sweep request, honoured only in IDLE
//   y_in      : cell output
//   vec_out   : cell inputs (bit0=a, bit1=b, bit2=c)
//   busy      : sweep running
//   done      : one-cycle pulse after the last code is captured
//   table_out : bit i = y captured while vec_out==i
//   expected  : (TT_CHECK_EN) golden truth table
//   mismatch  : (TT_CHECK_EN) table_out != expected, evaluated at sweep end
module tt_sweep_gen
  import tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = TT_SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 y_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out
`ifdef TT_CHECK_EN
  ,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 mismatch
`endif
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  tt_state_e state, state_d;
  logic      go;
  logic      tick;

  tt_settle_ctr #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (state == ST_RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    go      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        go      = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
        // the last code's capture edge is also the exit edge
        if (tick && vec_out == VEC_LAST) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_out   <= '0;
      table_out <= '0;
    end else if (go) begin
      vec_out   <= '0;
      table_out <= '0;
    end else if (tick) begin
      table_out[vec_out] <= y_in;
      // hold at the last code; FIN puts it back to 0
      if (vec_out != VEC_LAST) vec_out <= vec_out + N_IN'(1);
    end else if (state == ST_FIN) begin
      vec_out <= '0;
    end
  end

`ifdef TT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)               mismatch <= 1'b0;
    else if (go)              mismatch <= 1'b0;
    else if (state == ST_FIN) mismatch <= (table_out != expected);
  end
`endif

endmodule
